// File: rtl/vx_mem_bridge_pkg.sv
// Shared definitions for the Vortex memory port to generic bus bridge.
//   bridge_state_t : bridge FSM state encoding
//   beats()        : number of bus beats per cache line
//   beat_idx_w()   : width of the beat counter (at least 1 bit)
// The request/response entry structs depend on the bridge parameters, so
// they are declared next to those parameters in vx_mem_gbus_bridge.
package vx_mem_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RD_BEAT  = 2'd1,
        ST_WR_BEAT  = 2'd2,
        ST_RSP_PUSH = 2'd3
    } bridge_state_t;

    function automatic int beats(input int line_w, input int bus_w);
        return line_w / bus_w;
    endfunction

    function automatic int beat_idx_w(input int line_w, input int bus_w);
        int n;
        n = line_w / bus_w;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vx_bridge_fifo.sv
// Generic synchronous FIFO with registered storage.
//   clk, rst_n   : clock, asynchronous active-low reset (storage cleared)
//   push, wdata  : write side; push is ignored while full
//   pop, rdata   : read side; rdata shows the head entry, pop ignored while empty
//   full, empty  : occupancy flags
//   count        : number of stored entries
module vx_bridge_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // Explicit wrap so non power-of-two depths would still work.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = ptr_next(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/vx_mem_gbus_bridge.sv
// Bridge from the Vortex tagged cache-line memory port to the single-word
// generic bus with busy handshake.
//   mem_req_*  : Vortex request (valid/ready); queued in a REQ_DEPTH FIFO
//   mem_rsp_*  : Vortex read response (valid/ready) from a RSP_DEPTH FIFO
//   busy       : anything queued or in flight
//   gb_*       : generic bus master side, one BUS_W beat at a time
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; the sender holds its payload stable while valid && !ready.
// On the generic bus a beat completes on an edge where a strobe is high and
// gb_busy is low; address/data/enables are held until then.
module vx_mem_gbus_bridge
    import vx_mem_bridge_pkg::*;
#(
    parameter int LINE_W    = 512,
    parameter int ADDR_W    = 26,
    parameter int TAG_W     = 8,
    parameter int BUS_W     = 32,
    parameter int REQ_DEPTH = 4,
    parameter int RSP_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  nRST,
    input  logic                  mem_req_valid,
    input  logic                  mem_req_rw,
    input  logic [LINE_W/8-1:0]   mem_req_byteen,
    input  logic [ADDR_W-1:0]     mem_req_addr,
    input  logic [LINE_W-1:0]     mem_req_data,
    input  logic [TAG_W-1:0]      mem_req_tag,
    output logic                  mem_req_ready,
    output logic                  mem_rsp_valid,
    output logic [LINE_W-1:0]     mem_rsp_data,
    output logic [TAG_W-1:0]      mem_rsp_tag,
    input  logic                  mem_rsp_ready,
    output logic                  busy,
    output logic [31:0]           gb_addr,
    output logic [BUS_W-1:0]      gb_wdata,
    output logic [BUS_W/8-1:0]    gb_byte_en,
    output logic                  gb_ren,
    output logic                  gb_wen,
    input  logic [BUS_W-1:0]      gb_rdata,
    input  logic                  gb_busy
);
    localparam int BEATS_N    = beats(LINE_W, BUS_W);
    localparam int IDX_W      = beat_idx_w(LINE_W, BUS_W);
    localparam int BEN_W      = BUS_W / 8;
    localparam int LINE_OFF_W = $clog2(LINE_W / 8);

    typedef struct packed {
        logic                rw;
        logic [LINE_W/8-1:0] byteen;
        logic [ADDR_W-1:0]   addr;
        logic [LINE_W-1:0]   data;
        logic [TAG_W-1:0]    tag;
    } req_entry_t;

    typedef struct packed {
        logic [LINE_W-1:0] data;
        logic [TAG_W-1:0]  tag;
    } rsp_entry_t;

    req_entry_t req_in, req_head;
    rsp_entry_t rsp_in, rsp_head;
    logic       req_full, req_empty, req_pop;
    logic       rsp_full, rsp_empty, rsp_push;
    logic [$clog2(REQ_DEPTH+1)-1:0] req_count;
    logic [$clog2(RSP_DEPTH+1)-1:0] rsp_count;

    bridge_state_t       state_q, state_d;
    logic [IDX_W-1:0]    beat_q, beat_d;
    logic [LINE_W/8-1:0] work_ben_q, work_ben_d;
    logic [ADDR_W-1:0]   work_addr_q, work_addr_d;
    logic [LINE_W-1:0]   work_data_q, work_data_d;
    logic [TAG_W-1:0]    work_tag_q, work_tag_d;
    logic [LINE_W-1:0]   line_q, line_d;
    // Holds mem_req_ready low through reset and until the first edge after it.
    logic                ready_en_q;

    logic [31:0]         beat_addr;
    logic [BEN_W-1:0]    beat_en;
    logic [BUS_W-1:0]    beat_data;
    logic                last_beat;

    assign mem_req_ready = ready_en_q && !req_full;
    assign req_in        = '{rw: mem_req_rw, byteen: mem_req_byteen, addr: mem_req_addr,
                             data: mem_req_data, tag: mem_req_tag};
    assign rsp_in        = '{data: line_q, tag: work_tag_q};
    assign mem_rsp_valid = !rsp_empty;
    assign mem_rsp_data  = rsp_head.data;
    assign mem_rsp_tag   = rsp_head.tag;
    assign busy          = (req_count != '0) || (rsp_count != '0) || (state_q != ST_IDLE);

    vx_bridge_fifo #(.WIDTH($bits(req_entry_t)), .DEPTH(REQ_DEPTH)) u_req_fifo (
        .clk   (clk),
        .rst_n (nRST),
        .push  (mem_req_valid && mem_req_ready),
        .wdata (req_in),
        .pop   (req_pop),
        .rdata (req_head),
        .full  (req_full),
        .empty (req_empty),
        .count (req_count)
    );

    vx_bridge_fifo #(.WIDTH($bits(rsp_entry_t)), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk   (clk),
        .rst_n (nRST),
        .push  (rsp_push),
        .wdata (rsp_in),
        .pop   (mem_rsp_valid && mem_rsp_ready),
        .rdata (rsp_head),
        .full  (rsp_full),
        .empty (rsp_empty),
        .count (rsp_count)
    );

    assign beat_addr = (32'(work_addr_q) << LINE_OFF_W) + 32'(beat_q) * 32'(BEN_W);
    assign beat_en   = work_ben_q[int'(beat_q) * BEN_W +: BEN_W];
    assign beat_data = work_data_q[int'(beat_q) * BUS_W +: BUS_W];
    assign last_beat = (beat_q == IDX_W'(BEATS_N - 1));

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        work_ben_d  = work_ben_q;
        work_addr_d = work_addr_q;
        work_data_d = work_data_q;
        work_tag_d  = work_tag_q;
        line_d      = line_q;
        req_pop     = 1'b0;
        rsp_push    = 1'b0;
        gb_addr     = '0;
        gb_wdata    = '0;
        gb_byte_en  = '0;
        gb_ren      = 1'b0;
        gb_wen      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A read only starts once its response slot is guaranteed,
                // so RSP_PUSH can never find the response FIFO full.
                if (!req_empty && (req_head.rw || !rsp_full)) begin
                    req_pop     = 1'b1;
                    work_ben_d  = req_head.byteen;
                    work_addr_d = req_head.addr;
                    work_data_d = req_head.data;
                    work_tag_d  = req_head.tag;
                    beat_d      = '0;
                    state_d     = req_head.rw ? ST_WR_BEAT : ST_RD_BEAT;
                end
            end
            ST_RD_BEAT: begin
                gb_ren     = 1'b1;
                gb_addr    = beat_addr;
                gb_byte_en = '1;
                if (!gb_busy) begin
                    line_d[int'(beat_q) * BUS_W +: BUS_W] = gb_rdata;
                    if (last_beat) state_d = ST_RSP_PUSH;
                    else           beat_d  = beat_q + 1'b1;
                end
            end
            ST_WR_BEAT: begin
                // Beats with no enabled bytes are skipped without a bus cycle.
                if (beat_en != '0) begin
                    gb_wen     = 1'b1;
                    gb_addr    = beat_addr;
                    gb_wdata   = beat_data;
                    gb_byte_en = beat_en;
                end
                if (beat_en == '0 || !gb_busy) begin
                    if (last_beat) state_d = ST_IDLE;
                    else           beat_d  = beat_q + 1'b1;
                end
            end
            ST_RSP_PUSH: begin
                rsp_push = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            work_ben_q  <= '0;
            work_addr_q <= '0;
            work_data_q <= '0;
            work_tag_q  <= '0;
            line_q      <= '0;
            ready_en_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            work_ben_q  <= work_ben_d;
            work_addr_q <= work_addr_d;
            work_data_q <= work_data_d;
            work_tag_q  <= work_tag_d;
            line_q      <= line_d;
            ready_en_q  <= 1'b1;
        end
    end

endmodule
